// File: rtl/mac_acc_drain.sv
// mac_acc_drain
//   Sums runs of cfg_len consecutive unsigned mul_fp52 results into one
//   dot-product value and presents it on a valid/ready output. The sum
//   saturates at 2^ACC_W-1 and out_sat records whether any partial sum of
//   the vector overflowed.
//
// Ports
//   clk      : single clock, rising edge
//   rst      : asynchronous active-high reset
//   cfg_len  : terms per vector (0 treated as 1), sampled on a vector's first beat
//   in_vld   : in_res valid
//   in_rdy   : block accepts a term this cycle (beat = in_vld & in_rdy)
//   in_res   : unsigned term
//   out_vld  : out_sum/out_sat valid
//   out_rdy  : consumer accepts (handoff = out_vld & out_rdy)
//   out_sum  : saturated sum of the vector
//   out_sat  : the vector overflowed at least once
//   busy     : a vector is being accumulated or held for handoff
module mac_acc_drain #(
  parameter int RES_W = 18,
  parameter int ACC_W = 32,
  parameter int LEN_W = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [LEN_W-1:0] cfg_len,
  input  logic             in_vld,
  output logic             in_rdy,
  input  logic [RES_W-1:0] in_res,
  output logic             out_vld,
  input  logic             out_rdy,
  output logic [ACC_W-1:0] out_sum,
  output logic             out_sat,
  output logic             busy
);

  localparam int SUM_W = ACC_W + 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_ACC  = 2'd1,
    S_HOLD = 2'd2
  } state_t;

  state_t             state_q, state_d;
  logic [ACC_W-1:0]   acc_q, acc_d;
  logic [LEN_W-1:0]   cnt_q, cnt_d;
  logic [LEN_W-1:0]   len_q, len_d;
  logic               sat_q, sat_d;
  logic [ACC_W-1:0]   out_sum_q, out_sum_d;
  logic               out_sat_q, out_sat_d;

  logic               beat;
  logic [LEN_W-1:0]   len_new;
  logic [SUM_W-1:0]   add_res;

  // Returns {overflow, clamped sum}. Once the accumulator is at full scale,
  // adding a non-negative term keeps it there.
  function automatic logic [SUM_W-1:0] sat_add(input logic [ACC_W-1:0] a,
                                               input logic [RES_W-1:0] b);
    logic [SUM_W-1:0] s;
    s = {1'b0, a} + SUM_W'(b);
    if (s[ACC_W]) begin
      return {1'b1, {ACC_W{1'b1}}};
    end
    return s;
  endfunction

  // In HOLD the input is only opened when the result is leaving, so a new
  // vector can start in the same cycle as the handoff without a bubble.
  always_comb begin
    in_rdy = 1'b0;
    if (!rst) begin
      in_rdy = (state_q == S_HOLD) ? out_rdy : 1'b1;
    end
  end

  assign beat    = in_vld & in_rdy;
  assign len_new = (cfg_len == '0) ? LEN_W'(1) : cfg_len;
  assign add_res = sat_add(acc_q, in_res);

  always_comb begin
    state_d   = state_q;
    acc_d     = acc_q;
    cnt_d     = cnt_q;
    len_d     = len_q;
    sat_d     = sat_q;
    out_sum_d = out_sum_q;
    out_sat_d = out_sat_q;
    unique case (state_q)
      S_IDLE, S_HOLD: begin
        if (state_q == S_HOLD && out_rdy) begin
          state_d = S_IDLE;
        end
        // In HOLD a beat implies out_rdy, so this is always a fresh vector.
        if (beat) begin
          len_d = len_new;
          acc_d = ACC_W'(in_res);
          cnt_d = LEN_W'(1);
          sat_d = 1'b0;
          if (len_new == LEN_W'(1)) begin
            state_d   = S_HOLD;
            out_sum_d = ACC_W'(in_res);
            out_sat_d = 1'b0;
          end else begin
            state_d = S_ACC;
          end
        end
      end
      S_ACC: begin
        if (beat) begin
          acc_d = add_res[ACC_W-1:0];
          sat_d = sat_q | add_res[ACC_W];
          cnt_d = cnt_q + LEN_W'(1);
          if (cnt_d == len_q) begin
            state_d   = S_HOLD;
            out_sum_d = add_res[ACC_W-1:0];
            out_sat_d = sat_q | add_res[ACC_W];
          end
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q   <= S_IDLE;
      acc_q     <= '0;
      cnt_q     <= '0;
      len_q     <= '0;
      sat_q     <= 1'b0;
      out_sum_q <= '0;
      out_sat_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      acc_q     <= acc_d;
      cnt_q     <= cnt_d;
      len_q     <= len_d;
      sat_q     <= sat_d;
      out_sum_q <= out_sum_d;
      out_sat_q <= out_sat_d;
    end
  end

  assign out_vld = (state_q == S_HOLD);
  assign busy    = (state_q != S_IDLE);
  assign out_sum = out_sum_q;
  assign out_sat = out_sat_q;

endmodule

// File: tb/tb_mac_acc_drain.sv
module tb_mac_acc_drain;

  localparam int RES_W = 18;
  localparam int ACC_W = 20;
  localparam int LEN_W = 8;
  localparam longint MAXV = (64'd1 << ACC_W) - 1;
  localparam int TMAX = 254520;

  logic             clk = 1'b0;
  logic             rst;
  logic [LEN_W-1:0] cfg_len;
  logic             in_vld;
  logic             in_rdy;
  logic [RES_W-1:0] in_res;
  logic             out_vld;
  logic             out_rdy;
  logic [ACC_W-1:0] out_sum;
  logic             out_sat;
  logic             busy;

  mac_acc_drain #(.RES_W(RES_W), .ACC_W(ACC_W), .LEN_W(LEN_W)) dut (
    .clk(clk), .rst(rst), .cfg_len(cfg_len), .in_vld(in_vld), .in_rdy(in_rdy),
    .in_res(in_res), .out_vld(out_vld), .out_rdy(out_rdy), .out_sum(out_sum),
    .out_sat(out_sat), .busy(busy)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  // Reference model: a vector is a list of terms; its result is the running
  // sum clamped at full scale, with a flag if clamping ever happened.
  longint exp_sum_q[$];
  bit     exp_sat_q[$];
  bit     in_prog = 1'b0;
  int     m_len, m_n;
  longint m_sum;
  bit     m_sat;

  task automatic chk(input string nm, input longint act, input longint exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0d expected=%0d at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic model_beat(input longint x, input int len);
    if (!in_prog) begin
      in_prog = 1'b1;
      m_len = (len == 0) ? 1 : len;
      m_n = 0;
      m_sum = 0;
      m_sat = 1'b0;
    end
    m_sum += x;
    if (m_sum > MAXV) begin
      m_sum = MAXV;
      m_sat = 1'b1;
    end
    m_n++;
    if (m_n == m_len) begin
      exp_sum_q.push_back(m_sum);
      exp_sat_q.push_back(m_sat);
      in_prog = 1'b0;
    end
  endtask

  // One clock: inputs change just after the rising edge, the handshake is
  // evaluated at the falling edge and takes effect on the next rising edge.
  task automatic cycle(input bit v, input int r, input int l, input bit o);
    @(posedge clk);
    #1;
    in_vld  = v;
    in_res  = RES_W'(r);
    cfg_len = LEN_W'(l);
    out_rdy = o;
    @(negedge clk);
    if (in_vld && in_rdy) model_beat(longint'(in_res), int'(cfg_len));
  endtask

  task automatic expect_out(input string nm, input longint s, input bit sat);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < 10 && !seen; i++) begin
      if (out_vld) begin
        seen = 1'b1;
        chk({nm, "_sum"}, longint'(out_sum), s);
        chk({nm, "_sat"}, longint'(out_sat), longint'(sat));
      end else begin
        cycle(1'b0, 0, 0, 1'b1);
      end
    end
    if (!seen) chk({nm, "_timeout_out_vld"}, 0, 1);
  endtask

  task automatic do_reset(input string nm);
    @(posedge clk);
    #1;
    rst = 1'b1;
    in_vld = 1'b0;
    in_prog = 1'b0;
    exp_sum_q.delete();
    exp_sat_q.delete();
    #1;
    chk({nm, "_out_vld"}, longint'(out_vld), 0);
    chk({nm, "_out_sum"}, longint'(out_sum), 0);
    chk({nm, "_out_sat"}, longint'(out_sat), 0);
    chk({nm, "_busy"}, longint'(busy), 0);
    chk({nm, "_in_rdy"}, longint'(in_rdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
  endtask

  // Monitor: pops the scoreboard on every handoff and checks that a held
  // result neither drops nor changes before it is taken.
  bit               pv = 1'b0, ph = 1'b0;
  logic [ACC_W-1:0] psum;
  logic             psat;

  always @(negedge clk) begin
    if (rst) begin
      pv = 1'b0;
      ph = 1'b0;
    end else begin
      if (pv && !ph) begin
        chk("hold_vld", longint'(out_vld), 1);
        chk("hold_sum", longint'(out_sum), longint'(psum));
        chk("hold_sat", longint'(out_sat), longint'(psat));
      end
      if (out_vld && out_rdy) begin
        if (exp_sum_q.size() == 0) begin
          checks++;
          errors++;
          $display("FAIL sb_unexpected_output actual_sum=%0d expected=none", out_sum);
        end else begin
          chk("sb_sum", longint'(out_sum), exp_sum_q.pop_front());
          chk("sb_sat", longint'(out_sat), longint'(exp_sat_q.pop_front()));
        end
      end
      pv   = out_vld;
      ph   = out_vld && out_rdy;
      psum = out_sum;
      psat = out_sat;
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog actual=timeout required=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int nvld;
    rst = 1'b1;
    in_vld = 1'b0;
    in_res = '0;
    cfg_len = '0;
    out_rdy = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    chk("rst_out_vld", longint'(out_vld), 0);
    chk("rst_out_sum", longint'(out_sum), 0);
    chk("rst_busy", longint'(busy), 0);
    chk("rst_in_rdy", longint'(in_rdy), 0);
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("idle_in_rdy", longint'(in_rdy), 1);

    // 1: basic sum and one-cycle latency
    cycle(1'b1, 1, 4, 1'b1);
    cycle(1'b1, 2, 4, 1'b1);
    cycle(1'b1, 3, 4, 1'b1);
    cycle(1'b1, 4, 4, 1'b1);
    chk("t1_no_early_vld", longint'(out_vld), 0);
    cycle(1'b0, 0, 0, 1'b1);
    chk("t1_latency_vld", longint'(out_vld), 1);
    expect_out("t1", 10, 1'b0);

    // 2: saturation, then a clean vector starting on the handoff cycle
    for (int i = 0; i < 5; i++) cycle(1'b1, TMAX, 5, 1'b1);
    cycle(1'b1, 7, 1, 1'b1);
    chk("t2_vld", longint'(out_vld), 1);
    chk("t2_sum", longint'(out_sum), MAXV);
    chk("t2_sat", longint'(out_sat), 1);
    cycle(1'b0, 0, 0, 1'b1);
    expect_out("t2b", 7, 1'b0);

    // 3: backpressure
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b1, 100, 2, 1'b0);
    cycle(1'b1, 200, 2, 1'b0);
    for (int i = 0; i < 5; i++) begin
      cycle(1'b1, 9, 3, 1'b0);
      chk("t3_in_rdy", longint'(in_rdy), 0);
      chk("t3_vld", longint'(out_vld), 1);
      chk("t3_sum", longint'(out_sum), 300);
    end
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    chk("t3_idle_busy", longint'(busy), 0);

    // 4: back-to-back vectors without stalls
    nvld = 0;
    for (int i = 0; i < 9; i++) begin
      cycle(1'b1, 1, 3, 1'b1);
      chk("t4_in_rdy", longint'(in_rdy), 1);
      if (out_vld) begin
        nvld++;
        chk("t4_sum", longint'(out_sum), 3);
      end
    end
    cycle(1'b0, 0, 0, 1'b1);
    if (out_vld) begin
      nvld++;
      chk("t4_sum", longint'(out_sum), 3);
    end
    chk("t4_count", nvld, 3);

    // 5: cfg_len 0 means 1; cfg_len ignored after the first beat
    cycle(1'b1, 42, 0, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    chk("t5_len0_vld", longint'(out_vld), 1);
    chk("t5_len0_sum", longint'(out_sum), 42);
    cycle(1'b1, 5, 3, 1'b1);
    cycle(1'b1, 5, 7, 1'b1);
    cycle(1'b1, 5, 1, 1'b1);
    cycle(1'b0, 0, 0, 1'b1);
    chk("t5_mid_vld", longint'(out_vld), 1);
    chk("t5_mid_sum", longint'(out_sum), 15);

    // 6: reset mid-vector
    cycle(1'b0, 0, 0, 1'b1);
    cycle(1'b1, 5, 4, 1'b1);
    cycle(1'b1, 5, 4, 1'b1);
    do_reset("t6_rst");
    cycle(1'b1, 5, 2, 1'b1);
    cycle(1'b1, 6, 2, 1'b1);
    expect_out("t6", 11, 1'b0);
    cycle(1'b0, 0, 0, 1'b1);

    // Randomized traffic against the model
    for (int i = 0; i < 3000; i++) begin
      int r;
      if (i % 1000 == 500) do_reset("rnd_rst");
      r = ($urandom_range(0, 3) == 0) ? TMAX : int'($urandom_range(0, TMAX));
      cycle($urandom_range(0, 9) < 7, r, int'($urandom_range(0, 7)),
            $urandom_range(0, 9) < 7);
    end

    for (int i = 0; i < 50 && exp_sum_q.size() != 0; i++) cycle(1'b0, 0, 0, 1'b1);
    chk("drain_empty", exp_sum_q.size(), 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
